lpc_reg_bank: RTL and testbench
===============================

Name: lpc_reg_bank

Overview:
Parametrised LPC-side byte register bank: the next-generation FPGA control/status register file behind the LPC I/O decoder.
Adds several features over a fixed 32-byte bank:
- configurable depth and base address
- per-bit write, write-1-to-clear (W1C) and hardware read-only (RO) attributes
- hardware sticky-event capture
- registered read port
- out-of-range error flag and interrupt summary
Sits between the LPC cycle decoder (Addr/Wr/Rd strobes) and board logic (LED, fan, watchdog, system-OK fields).

Parameters:
NUM_REGS, 32, number of 8-bit registers (1..128).
ADDR_W, 8, width of Addr.
BASE_ADDR, 8'h00, address of register 0.
RST_VAL, {NUM_REGS{8'h00}}, flattened reset values, byte i at [8i+7:8i].
WR_MASK, {NUM_REGS{8'hFF}}, flattened; 1 = bit is software R/W.
W1C_MASK, {NUM_REGS{8'h00}}, flattened; 1 = bit is sticky, hardware-set, software write-1-to-clear.
RO_MASK, {NUM_REGS{8'h00}}, flattened; 1 = bit mirrors HwVal and is not writable.

Ports:
LpcClock  in  1  33 MHz LPC clock; all state on rising edge.
PciReset  in  1  asynchronous active-low reset.
Addr  in  ADDR_W  register address, valid with Wr/Rd.
Wr  in  1  single-cycle write strobe.
DataWr  in  8  write data.
Rd  in  1  single-cycle read strobe.
HwSet  in  8*NUM_REGS  per-bit sticky set pulses (effective only on W1C bits).
HwVal  in  8*NUM_REGS  live hardware values (effective only on RO bits).
DataRegFlat  out  8*NUM_REGS  current register contents, flattened.
RdData  out  8  read data.
RdValid  out  1  RdData valid pulse.
AddrErr  out  1  out-of-range access pulse.
IrqOut  out  1  OR of all W1C bits.

Behaviour:
- Reset (PciReset low, asynchronous):
  - each register bit = RST_VAL, except RO bits, which reset to 0
  - RdData = 8'h00, RdValid = 0, AddrErr = 0, IrqOut = 0
- Decode: hit when BASE_ADDR <= Addr < BASE_ADDR+NUM_REGS; index = Addr-BASE_ADDR.
- Mask attributes are disjoint per bit. Bits in none of WR/W1C/RO are constant at RST_VAL.
- Write (Wr & hit), register updates at the next edge:
  - WR bits := DataWr
  - W1C bits: cleared where DataWr = 1
  - other bits unchanged
- HwSet: every cycle, W1C bit := 1 where HwSet = 1. On a same-cycle HwSet and write-1-clear of the same bit, set wins; the bit stays 1.
- RO bits: sampled from HwVal every cycle (1-cycle latency); writes are ignored.
- Read (Rd): RdData and RdValid are registered one cycle after Rd. RdValid is high for exactly 1 cycle.
  - hit: RdData = register value before any same-cycle write (read-before-write).
  - miss: RdData = 8'hFF.
- AddrErr: 1-cycle pulse, one cycle after Wr or Rd with a miss. A miss write changes no state.
- Wr and Rd may be asserted together; both are performed.
- IrqOut: registered OR of all W1C bits, so it lags the bit change by 1 cycle.
- Reset mid-operation: any pending RdValid/AddrErr is cancelled immediately.

Optional Feature:
Macro LPC_REG_WRLOCK_EN.
With the macro defined:
- register index NUM_REGS-1 becomes a lock register.
- writing 8'hA5 sets the lock; writing 8'h5A clears it. No other value changes it, and the lock register reads back 8'h01 when locked, 8'h00 when unlocked.
- while locked, writes to every other register are ignored and pulse AddrErr.
- lock state resets to unlocked.
- W1C clears remain allowed while locked; only WR bits are frozen.
Without the macro: index NUM_REGS-1 is an ordinary register, and there is no lock logic.

Decomposition:
Package lpc_reg_pkg holds:
- typedef byte_t (logic [7:0])
- LOCK_KEY 8'hA5 and UNLOCK_KEY 8'h5A
- RD_MISS_VAL 8'hFF
- a function building flattened mask constants

One sub-module, lpc_reg_cell, is natural: a single 8-bit register implementing the WR/W1C/RO merge, generated NUM_REGS times. The top level owns decode, read mux, error, IRQ and lock.

Test Plan:
- Reset with RST_VAL byte0 = 8'h5A, then Rd Addr = 0 -> RdValid next cycle, RdData = 8'h5A, AddrErr = 0.
- WR_MASK byte4 = 8'h1B, reg = 8'h00; Wr Addr = 4 with DataWr = 8'hFF -> reg = 8'h1B.
- W1C_MASK byte2 = 8'h0F; pulse HwSet bit1 -> bit1 = 1, IrqOut = 1 the cycle after. Then Wr 8'h02 -> bit cleared, IrqOut = 0. Repeat with HwSet and the clear in the same cycle -> bit stays 1.
- NUM_REGS = 16, BASE_ADDR = 8'h40; Rd Addr = 8'h50 -> RdData = 8'hFF, AddrErr pulse. Wr 8'h3F -> no register change, AddrErr pulse.
- Wr and Rd same cycle, Addr = 1, old value 8'h55, DataWr = 8'hAA -> RdData = 8'h55; a following read returns 8'hAA.
- With LPC_REG_WRLOCK_EN: write 8'hA5 to the lock register, then Wr reg1 = 8'h00 -> reg1 unchanged, AddrErr pulse. Write 8'h5A, then Wr reg1 -> write takes effect.

Source files
------------

// File: rtl/lpc_reg_pkg.sv
// rtl/lpc_reg_pkg.sv - shared types, access keys and flattened-mask builders for the LPC register bank
package lpc_reg_pkg;

    typedef logic [7:0] byte_t;

    localparam int MAX_REGS = 128;
    typedef logic [8*MAX_REGS-1:0] flat_t;

    localparam byte_t LOCK_KEY    = 8'hA5;
    localparam byte_t UNLOCK_KEY  = 8'h5A;
    localparam byte_t RD_MISS_VAL = 8'hFF;

    // Every byte of a flattened constant set to the same value.
    function automatic flat_t fill_bytes(input byte_t val);
        flat_t r;
        for (int i = 0; i < MAX_REGS; i++) r[8*i +: 8] = val;
        return r;
    endfunction

    // Override one byte; chain calls to describe per-register masks.
    function automatic flat_t put_byte(input flat_t flat, input int idx, input byte_t val);
        flat_t r;
        r = flat;
        r[8*idx +: 8] = val;
        return r;
    endfunction

endpackage

// File: rtl/lpc_reg_bank_if.sv
// rtl/lpc_reg_bank_if.sv - decoder-side access bus (address, strobes, read data, error) of the register bank
interface lpc_reg_bank_if #(
    parameter int ADDR_W = 8
);
    import lpc_reg_pkg::*;

    logic [ADDR_W-1:0] Addr;
    logic              Wr;
    byte_t             DataWr;
    logic              Rd;
    byte_t             RdData;
    logic              RdValid;
    logic              AddrErr;

    modport master (output Addr, Wr, DataWr, Rd, input RdData, RdValid, AddrErr);
    modport slave  (input Addr, Wr, DataWr, Rd, output RdData, RdValid, AddrErr);

endinterface

// File: rtl/lpc_reg_cell.sv
// rtl/lpc_reg_cell.sv - one 8-bit register merging software R/W, sticky W1C and hardware read-only bits
module lpc_reg_cell
    import lpc_reg_pkg::*;
#(
    parameter byte_t RST_VAL  = 8'h00,
    parameter byte_t WR_MASK  = 8'hFF,
    parameter byte_t W1C_MASK = 8'h00,
    parameter byte_t RO_MASK  = 8'h00
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  wr_en,
    input  logic  clr_en,
    input  byte_t wr_data,
    input  byte_t hw_set,
    input  byte_t hw_val,
    output byte_t q
);

    localparam byte_t CONST_MASK = ~(WR_MASK | W1C_MASK | RO_MASK);

    byte_t d;

    // hw_set is applied after the clear so a same-cycle set always wins.
    always_comb begin
        d = q & (WR_MASK | W1C_MASK);
        if (wr_en)  d = (d & ~WR_MASK) | (wr_data & WR_MASK);
        if (clr_en) d = d & ~(wr_data & W1C_MASK);
        d = d | (hw_set & W1C_MASK) | (hw_val & RO_MASK) | (RST_VAL & CONST_MASK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST_VAL & ~RO_MASK;
        else        q <= d;
    end

endmodule

// File: rtl/lpc_reg_bank.sv
// rtl/lpc_reg_bank.sv - parametrised LPC byte register bank; LPC_REG_WRLOCK_EN adds a write-lock register
module lpc_reg_bank
    import lpc_reg_pkg::*;
#(
    parameter int                    NUM_REGS  = 32,
    parameter int                    ADDR_W    = 8,
    parameter logic [ADDR_W-1:0]     BASE_ADDR = '0,
    parameter logic [8*NUM_REGS-1:0] RST_VAL   = {NUM_REGS{8'h00}},
    parameter logic [8*NUM_REGS-1:0] WR_MASK   = {NUM_REGS{8'hFF}},
    parameter logic [8*NUM_REGS-1:0] W1C_MASK  = {NUM_REGS{8'h00}},
    parameter logic [8*NUM_REGS-1:0] RO_MASK   = {NUM_REGS{8'h00}}
) (
    input  logic                  LpcClock,
    input  logic                  PciReset,
    lpc_reg_bank_if.slave         bus,
    input  logic [8*NUM_REGS-1:0] HwSet,
    input  logic [8*NUM_REGS-1:0] HwVal,
    output logic [8*NUM_REGS-1:0] DataRegFlat,
    output logic                  IrqOut
);

    localparam int              IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(NUM_REGS);

    logic [ADDR_W:0]  offset;
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic             wr_hit;
    logic             lock_blk;
    byte_t            regs [NUM_REGS];

    // One extra bit catches addresses below the base as a borrow.
    assign offset = {1'b0, bus.Addr} - {1'b0, BASE_ADDR};
    assign hit    = !offset[ADDR_W] && (offset < SPAN);
    assign idx    = offset[IDX_W-1:0];
    assign wr_hit = bus.Wr && hit;

`ifdef LPC_REG_WRLOCK_EN
    localparam int LOCK_IDX = NUM_REGS - 1;

    logic locked;

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            locked <= 1'b0;
        end else if (wr_hit && (idx == IDX_W'(LOCK_IDX))) begin
            if (bus.DataWr == LOCK_KEY)        locked <= 1'b1;
            else if (bus.DataWr == UNLOCK_KEY) locked <= 1'b0;
        end
    end

    assign lock_blk = locked && (idx != IDX_W'(LOCK_IDX));
`else
    assign lock_blk = 1'b0;
`endif

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
`ifdef LPC_REG_WRLOCK_EN
        if (i == LOCK_IDX) begin : g_lock
            assign regs[i] = {7'b0, locked};
        end else begin : g_cell
`else
        if (1) begin : g_cell
`endif
            logic sel;
            assign sel = wr_hit && (idx == IDX_W'(i));
            // A lock freezes only the R/W bits; W1C clears still go through.
            lpc_reg_cell #(
                .RST_VAL  (RST_VAL[8*i +: 8]),
                .WR_MASK  (WR_MASK[8*i +: 8]),
                .W1C_MASK (W1C_MASK[8*i +: 8]),
                .RO_MASK  (RO_MASK[8*i +: 8])
            ) u_cell (
                .clk     (LpcClock),
                .rst_n   (PciReset),
                .wr_en   (sel && !lock_blk),
                .clr_en  (sel),
                .wr_data (bus.DataWr),
                .hw_set  (HwSet[8*i +: 8]),
                .hw_val  (HwVal[8*i +: 8]),
                .q       (regs[i])
            );
        end
        assign DataRegFlat[8*i +: 8] = regs[i];
    end

    always_ff @(posedge LpcClock or negedge PciReset) begin
        if (!PciReset) begin
            bus.RdData  <= 8'h00;
            bus.RdValid <= 1'b0;
            bus.AddrErr <= 1'b0;
            IrqOut      <= 1'b0;
        end else begin
            bus.RdValid <= bus.Rd;
            if (bus.Rd) bus.RdData <= hit ? regs[idx] : RD_MISS_VAL;
            bus.AddrErr <= ((bus.Rd || bus.Wr) && !hit) || (wr_hit && lock_blk);
            IrqOut      <= |(DataRegFlat & W1C_MASK);
        end
    end

endmodule

// File: tb/tb_lpc_reg_bank.sv
// tb/tb_lpc_reg_bank.sv - vector table, corner sequences and randomized model check of lpc_reg_bank
module tb_lpc_reg_bank;
    import lpc_reg_pkg::*;

    localparam int         N    = 16;
    localparam int         W    = 8*N;
    localparam logic [7:0] BASE = 8'h40;

    localparam flat_t RST_F = put_byte(put_byte(put_byte(put_byte(fill_bytes(8'h00), 0, 8'h5A), 3, 8'h77), 4, 8'h40), 5, 8'h81);
    localparam flat_t WR_F  = put_byte(put_byte(put_byte(put_byte(fill_bytes(8'hFF), 2, 8'hF0), 3, 8'h00), 4, 8'h1B), 5, 8'hC0);
    localparam flat_t W1C_F = put_byte(put_byte(fill_bytes(8'h00), 2, 8'h0F), 5, 8'h30);
    localparam flat_t RO_F  = put_byte(put_byte(fill_bytes(8'h00), 3, 8'hFF), 5, 8'h0C);

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] hw_set, hw_val, flat;
    logic         irq;

    lpc_reg_bank_if #(.ADDR_W(8)) bus ();

    lpc_reg_bank #(
        .NUM_REGS (N), .ADDR_W (8), .BASE_ADDR (BASE),
        .RST_VAL (RST_F[W-1:0]), .WR_MASK (WR_F[W-1:0]),
        .W1C_MASK (W1C_F[W-1:0]), .RO_MASK (RO_F[W-1:0])
    ) dut (
        .LpcClock (clk), .PciReset (rst_n), .bus (bus),
        .HwSet (hw_set), .HwVal (hw_val), .DataRegFlat (flat), .IrqOut (irq)
    );

    initial forever #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    byte_t rst_b [N], wr_b [N], w1c_b [N], ro_b [N], m_reg [N];
    bit    m_lock;
    bit    e_valid, e_err, e_irq;
    byte_t e_data;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic byte_t view(input int i);
`ifdef LPC_REG_WRLOCK_EN
        if (i == N-1) return {7'b0, m_lock};
`endif
        return m_reg[i];
    endfunction

    function automatic logic [W-1:0] model_flat();
        logic [W-1:0] f;
        for (int i = 0; i < N; i++) f[8*i +: 8] = view(i);
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_reg[i] = rst_b[i] & ~ro_b[i];
        m_lock = 0; e_valid = 0; e_err = 0; e_irq = 0; e_data = 8'h00;
    endtask

    // Predicts the state and outputs seen after the next rising edge.
    task automatic model_step(input logic [7:0] a, input bit w, input byte_t d, input bit r,
                              input logic [W-1:0] hs, input logic [W-1:0] hv);
        bit    hit, blk;
        int    idx;
        byte_t v;
        hit = (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + N);
        idx = int'(a) - int'(BASE);
        blk = 0;
`ifdef LPC_REG_WRLOCK_EN
        blk = m_lock && (idx != N-1);
`endif
        e_irq = 0;
        for (int i = 0; i < N; i++) if ((m_reg[i] & w1c_b[i]) != 0) e_irq = 1;
        e_valid = r;
        if (r) e_data = hit ? view(idx) : 8'hFF;
        e_err = ((r || w) && !hit) || (w && hit && blk);
        for (int i = 0; i < N; i++) begin
            v = m_reg[i];
            if (w && hit && idx == i) begin
                if (!blk) v = (v & ~wr_b[i]) | (d & wr_b[i]);
                v = v & ~(d & w1c_b[i]);
            end
            v = v | (hs[8*i +: 8] & w1c_b[i]);
            v = (v & ~ro_b[i]) | (hv[8*i +: 8] & ro_b[i]);
            m_reg[i] = v;
        end
`ifdef LPC_REG_WRLOCK_EN
        if (w && hit && idx == N-1) begin
            if (d == 8'hA5)      m_lock = 1;
            else if (d == 8'h5A) m_lock = 0;
        end
`endif
    endtask

    task automatic check_outputs(input string tag);
        check({tag, " regs"}, flat, model_flat());
        check({tag, " rd_valid"}, W'(bus.RdValid), W'(e_valid));
        if (e_valid) check({tag, " rd_data"}, W'(bus.RdData), W'(e_data));
        check({tag, " addr_err"}, W'(bus.AddrErr), W'(e_err));
        check({tag, " irq"}, W'(irq), W'(e_irq));
    endtask

    task automatic cycle(input string tag, input logic [7:0] a, input bit w, input byte_t d, input bit r,
                         input logic [W-1:0] hs, input logic [W-1:0] hv);
        bus.Addr = a; bus.Wr = w; bus.DataWr = d; bus.Rd = r;
        hw_set = hs; hw_val = hv;
        model_step(a, w, d, r, hs, hv);
        @(negedge clk);
        check_outputs(tag);
    endtask

    typedef struct {
        logic [7:0] addr; bit wr; byte_t data; bit rd; byte_t set2;
        bit x_valid; byte_t x_data; bit x_err; bit x_irq;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [7:0]   a;
        bit           w, r;
        byte_t        d;
        logic [W-1:0] hs, hv;
        string        tag;

        for (int i = 0; i < N; i++) begin
            rst_b[i] = RST_F[8*i +: 8]; wr_b[i] = WR_F[8*i +: 8];
            w1c_b[i] = W1C_F[8*i +: 8]; ro_b[i] = RO_F[8*i +: 8];
        end

        //            addr   wr  data   rd  set2   valid data   err irq
        vecs.push_back('{8'h40, 0, 8'h00, 1, 8'h00, 1, 8'h5A, 0, 0});
        vecs.push_back('{8'h44, 1, 8'hFF, 0, 8'h00, 0, 8'h00, 0, 0});
        vecs.push_back('{8'h44, 0, 8'h00, 1, 8'h00, 1, 8'h5B, 0, 0});
        vecs.push_back('{8'h40, 0, 8'h00, 0, 8'h02, 0, 8'h00, 0, 0});
        vecs.push_back('{8'h40, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1});
        vecs.push_back('{8'h42, 0, 8'h00, 1, 8'h00, 1, 8'h02, 0, 1});
        vecs.push_back('{8'h42, 1, 8'h02, 0, 8'h00, 0, 8'h00, 0, 1});
        vecs.push_back('{8'h40, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0});
        vecs.push_back('{8'h42, 1, 8'h02, 0, 8'h02, 0, 8'h00, 0, 0});
        vecs.push_back('{8'h42, 0, 8'h00, 1, 8'h00, 1, 8'h02, 0, 1});
        vecs.push_back('{8'h50, 0, 8'h00, 1, 8'h00, 1, 8'hFF, 1, 1});
        vecs.push_back('{8'h3F, 1, 8'h12, 0, 8'h00, 0, 8'h00, 1, 1});
        vecs.push_back('{8'h41, 1, 8'h55, 0, 8'h00, 0, 8'h00, 0, 1});
        vecs.push_back('{8'h41, 1, 8'hAA, 1, 8'h00, 1, 8'h55, 0, 1});
        vecs.push_back('{8'h41, 0, 8'h00, 1, 8'h00, 1, 8'hAA, 0, 1});
        vecs.push_back('{8'h42, 1, 8'h0F, 0, 8'h00, 0, 8'h00, 0, 1});
        vecs.push_back('{8'h42, 1, 8'hF0, 0, 8'h00, 0, 8'h00, 0, 0});
        vecs.push_back('{8'h42, 0, 8'h00, 1, 8'h00, 1, 8'hF0, 0, 0});
`ifdef LPC_REG_WRLOCK_EN
        vecs.push_back('{8'h4F, 1, 8'hA5, 0, 8'h00, 0, 8'h00, 0, 0});
        vecs.push_back('{8'h41, 1, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0});
        vecs.push_back('{8'h41, 0, 8'h00, 1, 8'h02, 1, 8'hAA, 0, 0});
        vecs.push_back('{8'h4F, 0, 8'h00, 1, 8'h00, 1, 8'h01, 0, 1});
        vecs.push_back('{8'h42, 1, 8'h0F, 0, 8'h00, 0, 8'h00, 1, 1});
        vecs.push_back('{8'h42, 0, 8'h00, 1, 8'h00, 1, 8'hF0, 0, 0});
        vecs.push_back('{8'h4F, 1, 8'h5A, 0, 8'h00, 0, 8'h00, 0, 0});
        vecs.push_back('{8'h41, 1, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0});
        vecs.push_back('{8'h41, 0, 8'h00, 1, 8'h00, 1, 8'h00, 0, 0});
        vecs.push_back('{8'h4F, 0, 8'h00, 1, 8'h00, 1, 8'h00, 0, 0});
`endif

        rst_n = 1'b0;
        bus.Addr = 8'h00; bus.Wr = 0; bus.DataWr = 8'h00; bus.Rd = 0;
        hw_set = '0; hw_val = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        check("reset rd_data", W'(bus.RdData), W'(8'h00));
        check("reset ro_byte3", W'(flat[31:24]), W'(8'h00));
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            tag = $sformatf("vec%0d", k);
            cycle(tag, vecs[k].addr, vecs[k].wr, vecs[k].data, vecs[k].rd, W'(vecs[k].set2) << 16, '0);
            check({tag, " x_valid"}, W'(bus.RdValid), W'(vecs[k].x_valid));
            if (vecs[k].x_valid) check({tag, " x_data"}, W'(bus.RdData), W'(vecs[k].x_data));
            check({tag, " x_err"}, W'(bus.AddrErr), W'(vecs[k].x_err));
            check({tag, " x_irq"}, W'(irq), W'(vecs[k].x_irq));
        end

        // Reset arriving mid-cycle must drop pending RdValid/AddrErr at once.
        cycle("pre_rst", 8'h50, 0, 8'h00, 1, '0, '0);
        bus.Rd = 0; bus.Addr = BASE;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("mid_rst");
        check("mid_rst rd_data", W'(bus.RdData), W'(8'h00));
        @(negedge clk);
        rst_n = 1'b1;

        for (int c = 0; c < 800; c++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 8'h3F;
            else if (sel == 1) a = 8'h50;
            else if (sel == 2) a = 8'($urandom);
            else               a = 8'(int'(BASE) + $urandom_range(0, N-1));
            w = ($urandom_range(0, 2) == 0);
            r = ($urandom_range(0, 2) == 0);
            d = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = ($urandom_range(0, 1) == 1) ? 8'hA5 : 8'h5A;
            for (int b = 0; b < N; b++) begin
                hs[8*b +: 8] = 8'($urandom & $urandom & $urandom);
                hv[8*b +: 8] = 8'($urandom);
            end
            cycle($sformatf("rnd%0d", c), a, w, d, r, hs, hv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
